// File: rtl/hs_pkg.sv
// Shared types for the valid/ready pipeline: slice timing-cut modes and
// the per-slice beat capacity of each mode.
package hs_pkg;

  typedef enum logic [1:0] {
    HS_FULL = 2'd0,
    HS_FWD  = 2'd1,
    HS_BWD  = 2'd2,
    HS_PASS = 2'd3
  } hs_mode_e;

  function automatic logic [1:0] hs_capacity(input hs_mode_e mode);
    logic [1:0] cap_s;
    case (mode)
      HS_FULL: cap_s = 2'd2;
      HS_FWD:  cap_s = 2'd1;
      HS_BWD:  cap_s = 2'd1;
      HS_PASS: cap_s = 2'd0;
      default: cap_s = 2'd0;
    endcase
    return cap_s;
  endfunction

endpackage

// File: rtl/hs_pipe_chk.sv
// Occupancy guard for hs_pipe: the beat counter must never wrap in either direction.
module hs_pipe_chk #(
  parameter int OCC_W   = 3,
  parameter int OCC_MAX = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             flush,
  input logic             in_fire,
  input logic             out_fire,
  input logic [OCC_W-1:0] occupancy
);

  occ_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(in_fire && !out_fire && (int'(occupancy) >= OCC_MAX)));

  occ_no_underflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(out_fire && !in_fire && (occupancy == {OCC_W{1'b0}})));

endmodule

// File: rtl/hs_slice.sv
// One valid/ready register slice.  MODE selects which handshake paths are cut;
// rst/flush empty the slice and block both handshakes in the same cycle.
module hs_slice
  import hs_pkg::*;
#(
  parameter int       WIDTH = 32,
  parameter hs_mode_e MODE  = HS_FULL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_valid_in,
  output logic             up_ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             dn_valid_out,
  input  logic             dn_ready_in
);

  logic clr_s;
  assign clr_s = rst | flush;

  if (MODE == HS_FULL) begin : g_full
    logic             main_v_r;
    logic             skid_v_r;
    logic [WIDTH-1:0] main_d_r;
    logic [WIDTH-1:0] skid_d_r;
    logic             in_fire_s;
    logic             out_fire_s;

    assign up_ready_out = ~skid_v_r & ~clr_s;
    assign dn_valid_out = main_v_r & ~clr_s;
    assign data_out     = main_d_r;
    assign in_fire_s    = up_valid_in & up_ready_out;
    assign out_fire_s   = dn_valid_out & dn_ready_in;

    // Main/skid update; the skid only ever fills while main is stalled.
    always_ff @(posedge clk) begin
      if (clr_s) begin
        main_v_r <= 1'b0;
        skid_v_r <= 1'b0;
        main_d_r <= {WIDTH{1'b0}};
        skid_d_r <= {WIDTH{1'b0}};
      end else if (out_fire_s) begin
        if (skid_v_r) begin
          main_d_r <= skid_d_r;
          skid_v_r <= 1'b0;
        end else begin
          main_v_r <= in_fire_s;
          if (in_fire_s) main_d_r <= data_in;
        end
      end else if (in_fire_s) begin
        if (main_v_r) begin
          skid_v_r <= 1'b1;
          skid_d_r <= data_in;
        end else begin
          main_v_r <= 1'b1;
          main_d_r <= data_in;
        end
      end
    end
  end else if (MODE == HS_FWD) begin : g_fwd
    logic             v_r;
    logic [WIDTH-1:0] d_r;

    assign up_ready_out = (~v_r | dn_ready_in) & ~clr_s;
    assign dn_valid_out = v_r & ~clr_s;
    assign data_out     = d_r;

    // Single forward register; refilled in the same cycle it drains.
    always_ff @(posedge clk) begin
      if (clr_s) begin
        v_r <= 1'b0;
        d_r <= {WIDTH{1'b0}};
      end else if (up_valid_in & up_ready_out) begin
        v_r <= 1'b1;
        d_r <= data_in;
      end else if (dn_valid_out & dn_ready_in) begin
        v_r <= 1'b0;
      end
    end
  end else if (MODE == HS_BWD) begin : g_bwd
    logic             skid_v_r;
    logic [WIDTH-1:0] skid_d_r;

    assign up_ready_out = ~skid_v_r & ~clr_s;
    assign dn_valid_out = (skid_v_r | up_valid_in) & ~clr_s;
    assign data_out     = skid_v_r ? skid_d_r : data_in;

    // With the skid empty ready is high, so a stalled valid beat is always accepted here.
    always_ff @(posedge clk) begin
      if (clr_s) begin
        skid_v_r <= 1'b0;
        skid_d_r <= {WIDTH{1'b0}};
      end else if (skid_v_r) begin
        if (dn_ready_in) skid_v_r <= 1'b0;
      end else if (up_valid_in & ~dn_ready_in) begin
        skid_v_r <= 1'b1;
        skid_d_r <= data_in;
      end
    end
  end else begin : g_pass
    assign up_ready_out = dn_ready_in & ~clr_s;
    assign dn_valid_out = up_valid_in & ~clr_s;
    assign data_out     = data_in;
  end

endmodule

// File: rtl/hs_pipe.sv
// Chain of DEPTH identical handshake slices with synchronous flush and a count
// of beats held between the upstream and downstream ports.
module hs_pipe
  import hs_pkg::*;
#(
  parameter int       WIDTH = 32,
  parameter int       DEPTH = 2,
  parameter hs_mode_e MODE  = HS_FULL
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [WIDTH-1:0]               data_in,
  input  logic                           up_valid_in,
  output logic                           up_ready_out,
  output logic [WIDTH-1:0]               data_out,
  output logic                           dn_valid_out,
  input  logic                           dn_ready_in,
  output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W   = $clog2(2*DEPTH+1);
  localparam int OCC_MAX = int'(hs_capacity(MODE)) * DEPTH;

  logic in_fire_s;
  logic out_fire_s;
  logic [OCC_W-1:0] occ_r;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] dat_in_s;
    logic [WIDTH-1:0] dat_out_s;
    logic             vld_in_s;
    logic             vld_out_s;
    logic             rdy_up_s;
    logic             rdy_dn_s;

    if (i == 0) begin : g_head
      assign dat_in_s     = data_in;
      assign vld_in_s     = up_valid_in;
      assign up_ready_out = rdy_up_s;
    end else begin : g_link
      assign dat_in_s = g_stage[i-1].dat_out_s;
      assign vld_in_s = g_stage[i-1].vld_out_s;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign rdy_dn_s     = dn_ready_in;
      assign data_out     = dat_out_s;
      assign dn_valid_out = vld_out_s;
    end else begin : g_next
      assign rdy_dn_s = g_stage[i+1].rdy_up_s;
    end

    hs_slice #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
    ) u_slice (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .data_in      (dat_in_s),
      .up_valid_in  (vld_in_s),
      .up_ready_out (rdy_up_s),
      .data_out     (dat_out_s),
      .dn_valid_out (vld_out_s),
      .dn_ready_in  (rdy_dn_s)
    );
  end

  assign in_fire_s  = up_valid_in & up_ready_out;
  assign out_fire_s = dn_valid_out & dn_ready_in;

  // Beat counter; simultaneous accept and deliver leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (in_fire_s & ~out_fire_s) begin
      occ_r <= occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
    end else if (out_fire_s & ~in_fire_s) begin
      occ_r <= occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
    end
  end

  assign occupancy = occ_r;

  hs_pipe_chk #(
    .OCC_W   (OCC_W),
    .OCC_MAX (OCC_MAX)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_fire   (in_fire_s),
    .out_fire  (out_fire_s),
    .occupancy (occ_r)
  );

endmodule

// File: tb/tb_hs_pipe.sv
// Scoreboard bench for hs_pipe: four instances (FULL/2, BWD/1, FWD/3, PASS/2)
// driven by directed sequences; a negedge monitor checks order, stability and occupancy.
module tb_hs_pipe;
  import hs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [3:0]       flush, up_valid, dn_ready;
  logic [3:0][31:0] din;
  logic [3:0]       up_ready, dn_valid;
  logic [3:0][31:0] dout;
  logic [3:0][2:0]  occ_all;

  logic        ur0, ur1, ur2, ur3, dv0, dv1, dv2, dv3;
  logic [31:0] do0, do1, do2, do3;
  logic [2:0]  occ0, occ2, occ3;
  logic [1:0]  occ1;

  assign up_ready = {ur3, ur2, ur1, ur0};
  assign dn_valid = {dv3, dv2, dv1, dv0};
  assign dout     = {do3, do2, do1, do0};
  assign occ_all  = {occ3, occ2, {1'b0, occ1}, occ0};

  hs_pipe #(.WIDTH(32), .DEPTH(2), .MODE(HS_FULL)) u_full (
    .clk(clk), .rst(rst), .flush(flush[0]), .data_in(din[0]), .up_valid_in(up_valid[0]),
    .up_ready_out(ur0), .data_out(do0), .dn_valid_out(dv0), .dn_ready_in(dn_ready[0]),
    .occupancy(occ0));
  hs_pipe #(.WIDTH(32), .DEPTH(1), .MODE(HS_BWD)) u_bwd (
    .clk(clk), .rst(rst), .flush(flush[1]), .data_in(din[1]), .up_valid_in(up_valid[1]),
    .up_ready_out(ur1), .data_out(do1), .dn_valid_out(dv1), .dn_ready_in(dn_ready[1]),
    .occupancy(occ1));
  hs_pipe #(.WIDTH(32), .DEPTH(3), .MODE(HS_FWD)) u_fwd (
    .clk(clk), .rst(rst), .flush(flush[2]), .data_in(din[2]), .up_valid_in(up_valid[2]),
    .up_ready_out(ur2), .data_out(do2), .dn_valid_out(dv2), .dn_ready_in(dn_ready[2]),
    .occupancy(occ2));
  hs_pipe #(.WIDTH(32), .DEPTH(2), .MODE(HS_PASS)) u_pass (
    .clk(clk), .rst(rst), .flush(flush[3]), .data_in(din[3]), .up_valid_in(up_valid[3]),
    .up_ready_out(ur3), .data_out(do3), .dn_valid_out(dv3), .dn_ready_in(dn_ready[3]),
    .occupancy(occ3));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [4][$];
  int out_cnt [4] = '{default: 0};
  logic [3:0]       prev_stall = 4'b0000;
  logic [3:0][31:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: occupancy vs beats in flight, hold-while-stalled, and in-order delivery.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("occ_dut%0d", d), 32'(occ_all[d]), 32'(exp_q[d].size()));
      if (prev_stall[d] && !rst && !flush[d]) begin
        chk($sformatf("hold_valid_dut%0d", d), 32'(dn_valid[d]), 32'd1);
        chk($sformatf("hold_data_dut%0d", d), dout[d], prev_data[d]);
      end
      if (rst || flush[d]) begin
        exp_q[d].delete();
        prev_stall[d] = 1'b0;
      end else begin
        if (up_valid[d] && up_ready[d]) exp_q[d].push_back(din[d]);
        if (dn_valid[d] && dn_ready[d]) begin
          out_cnt[d]++;
          if (exp_q[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat_dut%0d: got %0h expected no beat", d, dout[d]);
          end else begin
            chk($sformatf("order_dut%0d", d), dout[d], exp_q[d].pop_front());
          end
        end
        prev_stall[d] = dn_valid[d] & ~dn_ready[d];
        prev_data[d]  = dout[d];
      end
    end
  end

  task automatic send(input int d, input logic [31:0] v);
    logic acc;
    int   n;
    up_valid[d] = 1'b1;
    din[d]      = v;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = up_ready[d];
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout_dut%0d: value %0h not accepted within 200 cycles", d, v);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nacc;
    logic [31:0] v;
    int          sent;
    int          guard;
    logic        fired;
    logic        got;

    rst = 1'b1; flush = 4'b0; up_valid = 4'b0; dn_ready = 4'b0; din = '0;
    wait_cycles(3);

    // Reset state
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("rst_up_ready", 32'(up_ready[d]), 32'd0);
      chk("rst_dn_valid", 32'(dn_valid[d]), 32'd0);
    end
    chk("rst_dout_full", dout[0], 32'd0);
    chk("rst_dout_fwd", dout[2], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk("post_rst_ready", 32'(up_ready[d]), 32'd1);
    @(posedge clk); #1;

    // FULL/2 streaming: latency 2, back-to-back output
    dn_ready[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      up_valid[0] = 1'b1;
      din[0] = 32'(i);
      @(negedge clk);
      chk("t1_ready", 32'(up_ready[0]), 32'd1);
      if (i < 2) begin
        chk("t1_latency", 32'(dn_valid[0]), 32'd0);
      end else begin
        chk("t1_valid", 32'(dn_valid[0]), 32'd1);
        chk("t1_data", dout[0], 32'(i - 2));
      end
      @(posedge clk); #1;
    end
    up_valid[0] = 1'b0;
    wait_cycles(4);
    chk("t1_count", 32'(out_cnt[0]), 32'd16);

    // FULL/2 backpressure: exactly four beats fit
    dn_ready[0] = 1'b0;
    nacc = 0;
    v = 32'd16;
    for (int k = 0; k < 10; k++) begin
      up_valid[0] = 1'b1;
      din[0] = v;
      @(negedge clk);
      if (up_ready[0]) begin
        nacc++;
        v = v + 32'd1;
      end
      @(posedge clk); #1;
    end
    chk("t2_accepted", 32'(nacc), 32'd4);
    @(negedge clk);
    chk("t2_ready", 32'(up_ready[0]), 32'd0);
    chk("t2_occ", 32'(occ_all[0]), 32'd4);
    chk("t2_valid", 32'(dn_valid[0]), 32'd1);
    chk("t2_data", dout[0], 32'd16);
    @(posedge clk); #1;
    dn_ready[0] = 1'b1;
    send(0, v);
    up_valid[0] = 1'b0;
    wait_cycles(6);
    chk("t2_count", 32'(out_cnt[0]), 32'd21);

    // BWD/1: same-cycle pass-through, then skid capture
    dn_ready[1] = 1'b1;
    up_valid[1] = 1'b1;
    din[1] = 32'd7;
    @(negedge clk);
    chk("t3_valid", 32'(dn_valid[1]), 32'd1);
    chk("t3_data", dout[1], 32'd7);
    chk("t3_ready", 32'(up_ready[1]), 32'd1);
    @(posedge clk); #1;
    dn_ready[1] = 1'b0;
    din[1] = 32'd8;
    @(negedge clk);
    chk("t3_ready_empty", 32'(up_ready[1]), 32'd1);
    chk("t3_data8", dout[1], 32'd8);
    @(posedge clk); #1;
    up_valid[1] = 1'b0;
    @(negedge clk);
    chk("t3_ready_full", 32'(up_ready[1]), 32'd0);
    chk("t3_skid_valid", 32'(dn_valid[1]), 32'd1);
    chk("t3_skid_data", dout[1], 32'd8);
    chk("t3_occ", 32'(occ_all[1]), 32'd1);
    @(posedge clk); #1;
    dn_ready[1] = 1'b1;
    wait_cycles(2);
    chk("t3_count", 32'(out_cnt[1]), 32'd2);

    // FULL/2 flush with a beat offered in the flush cycle
    dn_ready[0] = 1'b0;
    send(0, 32'd30); send(0, 32'd31); send(0, 32'd32);
    up_valid[0] = 1'b0;
    @(negedge clk);
    chk("t4_loaded", 32'(occ_all[0]), 32'd3);
    @(posedge clk); #1;
    flush[0] = 1'b1;
    up_valid[0] = 1'b1;
    din[0] = 32'd50;
    @(negedge clk);
    chk("t4_flush_ready", 32'(up_ready[0]), 32'd0);
    chk("t4_flush_valid", 32'(dn_valid[0]), 32'd0);
    @(posedge clk); #1;
    flush[0] = 1'b0;
    up_valid[0] = 1'b0;
    @(negedge clk);
    chk("t4_occ_cleared", 32'(occ_all[0]), 32'd0);
    chk("t4_valid_cleared", 32'(dn_valid[0]), 32'd0);
    @(posedge clk); #1;
    dn_ready[0] = 1'b1;
    send(0, 32'd99);
    up_valid[0] = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (dn_valid[0] && !got) begin
        chk("t4_first_after_flush", dout[0], 32'd99);
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL t4_timeout: got no beat expected 63");
    end

    // FWD/3: random valid/ready, 1000 beats
    sent = 0;
    guard = 0;
    while (sent < 1000 && guard < 20000) begin
      if (!up_valid[2] && ($urandom_range(1, 0) == 1)) begin
        up_valid[2] = 1'b1;
        din[2] = $urandom;
      end
      dn_ready[2] = ($urandom_range(1, 0) == 1);
      @(negedge clk);
      fired = up_valid[2] & up_ready[2];
      @(posedge clk); #1;
      if (fired) begin
        sent++;
        up_valid[2] = 1'b0;
      end
      guard++;
    end
    up_valid[2] = 1'b0;
    dn_ready[2] = 1'b1;
    wait_cycles(6);
    chk("t5_sent", 32'(sent), 32'd1000);
    chk("t5_delivered", 32'(out_cnt[2]), 32'd1000);

    // Reset mid-stream with beats held, then 0..3 through every mode
    dn_ready = 4'b0000;
    send(0, 32'd40); send(0, 32'd41); up_valid[0] = 1'b0;
    send(2, 32'd42); send(2, 32'd43); up_valid[2] = 1'b0;
    send(1, 32'd44); up_valid[1] = 1'b0;
    rst = 1'b1;
    up_valid = 4'b1111;
    dn_ready = 4'b1111;
    din = {32'd53, 32'd52, 32'd51, 32'd50};
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("t6_rst_ready", 32'(up_ready[d]), 32'd0);
      chk("t6_rst_valid", 32'(dn_valid[d]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    up_valid = 4'b0000;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("t6_occ_zero", 32'(occ_all[d]), 32'd0);
      chk("t6_valid_zero", 32'(dn_valid[d]), 32'd0);
      chk("t6_ready_one", 32'(up_ready[d]), 32'd1);
    end
    chk("t6_dout_full", dout[0], 32'd0);
    chk("t6_dout_fwd", dout[2], 32'd0);
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) send(d, 32'(k));
      up_valid[d] = 1'b0;
    end
    wait_cycles(6);
    for (int d = 0; d < 4; d++) chk("t6_drained", 32'(exp_q[d].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
